botupd_irq_bridge: RTL and testbench

BOTUPD_IRQ_BRIDGE -- requirements
Module: botupd_irq_bridge

---
 rtl/botupd_irq_bridge.sv | 143 ++++++++++++++
 tb/tb_botupd_irq_bridge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/botupd_irq_bridge.sv
// Bot-update interrupt bridge: synchronizes the bot-domain update toggle, waits for
// the bot registers to settle, snapshots them and raises an acknowledgeable interrupt.
module botupd_irq_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int OVF_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_upd_tgl,
  input  logic [7:0]       i_loc_x,
  input  logic [7:0]       i_loc_y,
  input  logic [7:0]       i_sensors,
  input  logic [7:0]       i_botinfo,
  input  logic             i_ack,
  input  logic             i_ovf_clr,
  output logic             o_irq,
  output logic [31:0]      o_snap,
  output logic [15:0]      o_upd_cnt,
  output logic [OVF_W-1:0] o_ovf_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, PEND} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   upd_edge;
  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic                   capture;
  logic                   ovf_inc;
  logic                   irq_clr;

  // Synchronizer chain plus one delayed copy of its last stage for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_upd_tgl};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign upd_edge = sync_q[SYNC_STAGES-1] ^ prev_q;

  // State register and settle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (upd_edge) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd0;
        end
      end
      SETTLE: begin
        if (upd_edge) begin
          cnt_nxt = 8'd0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = PEND;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      PEND: begin
        if (upd_edge) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd0;
        end else if (i_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // An edge during SETTLE, or during PEND without a same-cycle ack, is an overrun
  always_comb begin
    capture = 1'b0;
    ovf_inc = 1'b0;
    irq_clr = 1'b0;
    case (state)
      SETTLE: begin
        capture = !upd_edge && (cnt == SETTLE_LAST);
        ovf_inc = upd_edge;
        irq_clr = i_ack;
      end
      PEND: begin
        ovf_inc = upd_edge && !i_ack;
        irq_clr = i_ack;
      end
      default: begin
        capture = 1'b0;
      end
    endcase
  end

  // Interrupt, snapshot and capture counter; a capture wins over a same-cycle ack
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_irq     <= 1'b0;
      o_snap    <= 32'd0;
      o_upd_cnt <= 16'd0;
    end else begin
      if (capture) begin
        o_irq     <= 1'b1;
        o_snap    <= {i_loc_x, i_loc_y, i_sensors, i_botinfo};
        o_upd_cnt <= o_upd_cnt + 16'd1;
      end else if (irq_clr) begin
        o_irq <= 1'b0;
      end
    end
  end

  // Saturating overrun counter; a clear coincident with an overrun leaves one count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ovf_cnt <= '0;
    end else if (i_ovf_clr) begin
      o_ovf_cnt <= ovf_inc ? OVF_W'(1) : '0;
    end else if (ovf_inc && (o_ovf_cnt != {OVF_W{1'b1}})) begin
      o_ovf_cnt <= o_ovf_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_botupd_irq_bridge.sv
// Directed bench for botupd_irq_bridge: default instance plus a 2-bit overrun-counter
// instance for saturation and clear-coincident-with-overrun behaviour.
module tb_botupd_irq_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tgl0, tgl1;
  logic [7:0]  loc_x, loc_y, sensors, botinfo;
  logic        ack0, ack1, clr0, clr1;
  logic        irq0, irq1;
  logic [31:0] snap0, snap1;
  logic [15:0] upd0, upd1;
  logic [7:0]  ovf0;
  logic [1:0]  ovf1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  botupd_irq_bridge dut0 (
    .clk(clk), .rstn(rstn), .i_upd_tgl(tgl0),
    .i_loc_x(loc_x), .i_loc_y(loc_y), .i_sensors(sensors), .i_botinfo(botinfo),
    .i_ack(ack0), .i_ovf_clr(clr0),
    .o_irq(irq0), .o_snap(snap0), .o_upd_cnt(upd0), .o_ovf_cnt(ovf0)
  );

  botupd_irq_bridge #(.SYNC_STAGES(2), .SETTLE_CYC(4), .OVF_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .i_upd_tgl(tgl1),
    .i_loc_x(loc_x), .i_loc_y(loc_y), .i_sensors(sensors), .i_botinfo(botinfo),
    .i_ack(ack1), .i_ovf_clr(clr1),
    .o_irq(irq1), .o_snap(snap1), .o_upd_cnt(upd1), .o_ovf_cnt(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    tgl0 = 1'b0; tgl1 = 1'b0;
    ack0 = 1'b0; ack1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    loc_x = 8'h12; loc_y = 8'h34; sensors = 8'h56; botinfo = 8'h78;
    cyc(3);
    chk("rst_irq", 32'(irq0), 32'd0);
    chk("rst_snap", snap0, 32'd0);
    chk("rst_upd", 32'(upd0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    rstn = 1'b1;
    cyc(2);

    // First update: capture after N+6
    tgl0 = 1'b1;
    cyc(6);
    chk("lat_irq_n5", 32'(irq0), 32'd0);
    cyc(1);
    chk("lat_irq_n6", 32'(irq0), 32'd1);
    chk("first_snap", snap0, 32'h12345678);
    chk("first_upd", 32'(upd0), 32'd1);

    // Ack, then a second update
    ack0 = 1'b1;
    cyc(1);
    ack0 = 1'b0;
    chk("ack_irq", 32'(irq0), 32'd0);
    tgl0 = 1'b0;
    cyc(6);
    chk("second_irq_n5", 32'(irq0), 32'd0);
    cyc(1);
    chk("second_irq_n6", 32'(irq0), 32'd1);
    chk("second_upd", 32'(upd0), 32'd2);

    // Unacknowledged update while pending: overrun, snapshot held until recapture
    loc_x = 8'hA1; loc_y = 8'hB2; sensors = 8'hC3; botinfo = 8'hD4;
    tgl0 = 1'b1;
    cyc(3);
    chk("ovr_cnt", 32'(ovf0), 32'd1);
    chk("ovr_irq_held", 32'(irq0), 32'd1);
    chk("ovr_snap_held", snap0, 32'h12345678);
    cyc(3);
    chk("ovr_snap_n5", snap0, 32'h12345678);
    cyc(1);
    chk("ovr_snap_new", snap0, 32'hA1B2C3D4);
    chk("ovr_upd", 32'(upd0), 32'd3);
    chk("ovr_irq", 32'(irq0), 32'd1);

    // Ack coincident with an edge in PEND: irq drops, no overrun
    tgl0 = 1'b0;
    cyc(2);
    ack0 = 1'b1;
    cyc(1);
    ack0 = 1'b0;
    chk("coinc_irq_low", 32'(irq0), 32'd0);
    chk("coinc_ovf", 32'(ovf0), 32'd1);
    cyc(3);
    chk("coinc_irq_n5", 32'(irq0), 32'd0);
    cyc(1);
    chk("coinc_irq_n6", 32'(irq0), 32'd1);
    chk("coinc_upd", 32'(upd0), 32'd4);
    chk("coinc_ovf_after", 32'(ovf0), 32'd1);

    // Plain overrun-counter clear
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    chk("ovf_clr", 32'(ovf0), 32'd0);

    // Reset two cycles into SETTLE, then release with toggle high
    tgl0 = 1'b1;
    cyc(5);
    rstn = 1'b0;
    #1;
    chk("async_irq", 32'(irq0), 32'd0);
    chk("async_snap", snap0, 32'd0);
    chk("async_upd", 32'(upd0), 32'd0);
    chk("async_ovf", 32'(ovf0), 32'd0);
    cyc(2);
    loc_x = 8'h0F; loc_y = 8'h1E; sensors = 8'h2D; botinfo = 8'h3C;
    rstn = 1'b1;
    cyc(6);
    chk("rel_irq_n5", 32'(irq0), 32'd0);
    cyc(1);
    chk("rel_irq_n6", 32'(irq0), 32'd1);
    chk("rel_snap", snap0, 32'h0F1E2D3C);
    cyc(20);
    chk("rel_single_upd", 32'(upd0), 32'd1);
    chk("rel_ovf", 32'(ovf0), 32'd0);

    // 2-bit overrun counter: five unacknowledged toggles saturate at 3
    for (int i = 0; i < 5; i++) begin
      tgl1 = ~tgl1;
      cyc(8);
      chk($sformatf("sat_ovf_%0d", i), 32'(ovf1), (i > 3) ? 32'd3 : 32'(i));
    end
    chk("sat_upd", 32'(upd1), 32'd5);
    chk("sat_irq", 32'(irq1), 32'd1);

    // Clear coincident with a further overrun leaves one count
    tgl1 = ~tgl1;
    cyc(2);
    clr1 = 1'b1;
    cyc(1);
    clr1 = 1'b0;
    chk("clr_coinc_ovf", 32'(ovf1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
